// File: rtl/sram_like_arbiter.sv
// N-channel arbiter/bridge from CPU-side request ports onto one sram-like bus.
// One outstanding transaction; optional fixed kseg0/kseg1 address translation.
module sram_like_arbiter #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAP_EN    = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH-1:0]        ch_wr,
  input  logic [DW/8*N_CH-1:0]   ch_wstrb,
  input  logic [AW*N_CH-1:0]     ch_addr,
  input  logic [DW*N_CH-1:0]     ch_wdata,
  output logic [N_CH-1:0]        ch_addr_ok,
  output logic [N_CH-1:0]        ch_data_ok,
  output logic [DW-1:0]          ch_rdata,
  output logic                   mem_req,
  output logic                   mem_wr,
  output logic [DW/8-1:0]        mem_wstrb,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_addr_ok,
  input  logic                   mem_data_ok,
  input  logic [DW-1:0]          mem_rdata,
  output logic                   busy
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   grant, rr_ptr, winner, rr_next;
  logic            win_valid;
  logic [N_CH-1:0] grant_oh;

  // kseg0/kseg1 (top three bits 100/101) map onto physical address 0.
  function automatic logic [AW-1:0] xlate(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    if (MAP_EN != 0 && (a[AW-1 -: 3] == 3'b100 || a[AW-1 -: 3] == 3'b101))
      r[AW-1 -: 3] = 3'b000;
    return r;
  endfunction

  // Round-robin scans N_CH candidates starting at rr_ptr; fixed mode starts at 0.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] cand;
    winner    = '0;
    win_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (PRIO_MODE != 0) ? 32'(rr_ptr) + k : k;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = GW'(idx);
      if (!win_valid && ch_req[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
    rr_next = (winner == GW'(N_CH - 1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (win_valid) state_n = REQ;
      REQ:     if (mem_addr_ok) state_n = mem_data_ok ? IDLE : WAIT;
      WAIT:    if (mem_data_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
    ch_addr_ok      = (state == REQ && mem_addr_ok) ? grant_oh : '0;
    ch_data_ok      = ((state == REQ && mem_addr_ok && mem_data_ok) ||
                       (state == WAIT && mem_data_ok)) ? grant_oh : '0;
  end

  assign ch_rdata = mem_rdata;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant     <= '0;
      rr_ptr    <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && win_valid) begin
      grant     <= winner;
      rr_ptr    <= rr_next;
      mem_req   <= 1'b1;
      mem_wr    <= ch_wr[winner];
      mem_wstrb <= ch_wstrb[SW*winner +: SW];
      mem_addr  <= xlate(ch_addr[AW*winner +: AW]);
      mem_wdata <= ch_wdata[DW*winner +: DW];
    end else if (state == REQ && mem_addr_ok) begin
      mem_req   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: fixed-priority and round-robin instances share stimulus.
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [1:0]  ch_req, ch_wr;
  logic [7:0]  ch_wstrb;
  logic [63:0] ch_addr, ch_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic [1:0]  ao0, ao1, do0, do1;
  logic [31:0] rd0, rd1, maddr0, maddr1, mwd0, mwd1;
  logic        mreq0, mreq1, mwr0, mwr1, busy0, busy1;
  logic [3:0]  mstrb0, mstrb1;

  sram_like_arbiter #(.N_CH(2), .AW(32), .DW(32), .PRIO_MODE(0), .MAP_EN(1)) u_fix (
    .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ao0), .ch_data_ok(do0),
    .ch_rdata(rd0), .mem_req(mreq0), .mem_wr(mwr0), .mem_wstrb(mstrb0),
    .mem_addr(maddr0), .mem_wdata(mwd0), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy0));

  sram_like_arbiter #(.N_CH(2), .AW(32), .DW(32), .PRIO_MODE(1), .MAP_EN(1)) u_rr (
    .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ao1), .ch_data_ok(do1),
    .ch_rdata(rd1), .mem_req(mreq1), .mem_wr(mwr1), .mem_wstrb(mstrb1),
    .mem_addr(maddr1), .mem_wdata(mwd1), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy1));

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          aw;     // REQ cycles before mem_addr_ok
    int          dw;     // WAIT cycles before mem_data_ok; -1 = same cycle as addr_ok
    logic [31:0] rdata;
    bit          noise;  // spurious mem_data_ok where it must be ignored
    int          eg0;    // expected fixed-priority grant
    logic [31:0] ea0;    // expected fixed-priority mem_addr
  } vec_t;

  int checks = 0;
  int passed = 0;
  int rr_m   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference rules: kseg0/kseg1 is the range 0x8000_0000..0xBFFF_FFFF.
  function automatic logic [31:0] xlate(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  function automatic int pick_fixed(input logic [1:0] r);
    for (int i = 0; i < 2; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int pick_rr(input logic [1:0] r);
    for (int k = 0; k < 2; k++) if (r[(rr_m + k) % 2]) return (rr_m + k) % 2;
    return 0;
  endfunction

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] wr,
                              input logic [31:0] a1, input logic [31:0] a0,
                              input logic [31:0] d1, input logic [31:0] d0,
                              input logic [7:0] st, input int aw, input int dw,
                              input logic [31:0] rdata, input bit noise,
                              input int eg0, input logic [31:0] ea0);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = {a1, a0}; v.wdata = {d1, d0}; v.wstrb = st;
    v.aw = aw; v.dw = dw; v.rdata = rdata; v.noise = noise; v.eg0 = eg0; v.ea0 = ea0;
    return v;
  endfunction

  task automatic reset_chk();
    resetn = 1'b0;
    #1;
    chk("rst_mem_req",   {mreq1, mreq0}, 2'b00);
    chk("rst_mem_wr",    {mwr1, mwr0}, 2'b00);
    chk("rst_mem_wstrb", {mstrb1, mstrb0}, 8'h00);
    chk("rst_mem_addr",  {maddr1, maddr0}, 64'h0);
    chk("rst_mem_wdata", {mwd1, mwd0}, 64'h0);
    chk("rst_addr_ok",   {ao1, ao0}, 4'b0);
    chk("rst_data_ok",   {do1, do0}, 4'b0);
    chk("rst_busy",      {busy1, busy0}, 2'b00);
  endtask

  // Called just after a negedge with both DUTs idle; returns just after a negedge, idle.
  task automatic do_txn(input vec_t v, input bit keep);
    int g0, g1;
    logic [31:0] ea1;
    logic [1:0]  oh0, oh1;
    g0  = v.eg0;
    g1  = pick_rr(v.req);
    rr_m = (g1 + 1) % 2;
    ea1 = xlate(v.addr[32*g1 +: 32]);
    oh0 = 2'b01 << g0;
    oh1 = 2'b01 << g1;
    ch_req = v.req; ch_wr = v.wr; ch_addr = v.addr; ch_wdata = v.wdata; ch_wstrb = v.wstrb;
    @(negedge clk);
    if (!keep) begin
      ch_req = '0; ch_wr = ~v.wr; ch_addr = ~v.addr; ch_wdata = ~v.wdata; ch_wstrb = ~v.wstrb;
    end
    for (int i = 0; i <= v.aw; i++) begin
      mem_addr_ok = (i == v.aw);
      mem_data_ok = (i == v.aw) ? (v.dw < 0) : v.noise;
      mem_rdata   = v.rdata;
      #1;
      chk("req_mem_req",  {mreq1, mreq0}, 2'b11);
      chk("req_addr_fix", maddr0, v.ea0);
      chk("req_addr_rr",  maddr1, ea1);
      chk("req_wr",       {mwr1, mwr0}, {v.wr[g1], v.wr[g0]});
      chk("req_wstrb",    {mstrb1, mstrb0}, {v.wstrb[4*g1 +: 4], v.wstrb[4*g0 +: 4]});
      chk("req_wdata",    {mwd1, mwd0}, {v.wdata[32*g1 +: 32], v.wdata[32*g0 +: 32]});
      chk("req_addr_ok",  {ao1, ao0}, (i == v.aw) ? {oh1, oh0} : 4'b0);
      chk("req_data_ok",  {do1, do0}, (i == v.aw && v.dw < 0) ? {oh1, oh0} : 4'b0);
      if (i == v.aw && v.dw < 0) chk("req_rdata", {rd1, rd0}, {v.rdata, v.rdata});
      chk("req_busy",     {busy1, busy0}, 2'b11);
      @(negedge clk);
    end
    mem_addr_ok = 1'b0;
    for (int j = 0; j <= v.dw; j++) begin
      mem_data_ok = (j == v.dw);
      mem_rdata   = (j == v.dw) ? v.rdata : $urandom;
      #1;
      chk("wait_mem_req", {mreq1, mreq0}, 2'b00);
      chk("wait_addr_ok", {ao1, ao0}, 4'b0);
      chk("wait_data_ok", {do1, do0}, (j == v.dw) ? {oh1, oh0} : 4'b0);
      if (j == v.dw) chk("wait_rdata", {rd1, rd0}, {v.rdata, v.rdata});
      chk("wait_busy",    {busy1, busy0}, 2'b11);
      @(negedge clk);
    end
    mem_data_ok = v.noise;
    #1;
    chk("done_busy",    {busy1, busy0}, 2'b00);
    chk("done_data_ok", {do1, do0}, 4'b0);
    chk("done_mem_req", {mreq1, mreq0}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    logic [31:0] a0, a1;

    tbl[0] = mk(2'b01, 2'b00, 32'h0, 32'h0000_1000, 32'h0, 32'h0, 8'h00, 0, 0,
                32'h1111_2222, 1'b1, 0, 32'h0000_1000);
    tbl[1] = mk(2'b10, 2'b00, 32'hBFC0_0000, 32'h0000_0040, 32'h0, 32'h0, 8'h00, 0, 0,
                32'h2408_0001, 1'b0, 1, 32'h1FC0_0000);
    tbl[2] = mk(2'b01, 2'b01, 32'h0, 32'h8000_0010, 32'h0, 32'h1234_5678, 8'h03, 2, 0,
                32'h0, 1'b0, 0, 32'h0000_0010);
    tbl[3] = mk(2'b01, 2'b00, 32'h0, 32'hA000_0004, 32'h0, 32'h0, 8'h00, 1, -1,
                32'hDEAD_BEEF, 1'b0, 0, 32'h0000_0004);
    tbl[4] = mk(2'b11, 2'b10, 32'h8000_0000, 32'hC000_0000, 32'hAAAA_0001, 32'h5555_0000,
                8'hF5, 0, 2, 32'h0, 1'b1, 0, 32'hC000_0000);
    tbl[5] = mk(2'b10, 2'b10, 32'h6000_1234, 32'h0, 32'hCAFE_F00D, 32'h0, 8'h00, 1, 1,
                32'h0, 1'b0, 1, 32'h6000_1234);
    tbl[6] = mk(2'b10, 2'b00, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 8'h00, 3, 3,
                32'h0BAD_CAFE, 1'b1, 1, 32'hFFFF_FFFC);
    tbl[7] = mk(2'b11, 2'b00, 32'hA000_0000, 32'h9FFF_FFFF, 32'h0, 32'h0, 8'h00, 0, 0,
                32'h7777_0000, 1'b0, 0, 32'h1FFF_FFFF);

    resetn = 1'b0; ch_req = '0; ch_wr = '0; ch_wstrb = '0; ch_addr = '0; ch_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    @(negedge clk);
    reset_chk();
    @(negedge clk);
    resetn = 1'b1;
    rr_m = 0;

    // Spurious data_ok while idle must be ignored.
    mem_data_ok = 1'b1;
    #1;
    chk("idle_spurious_data_ok", {do1, do0}, 4'b0);
    chk("idle_spurious_busy", {busy1, busy0}, 2'b00);
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_txn(tbl[i], 1'b0);

    // Both channels held across four back-to-back transactions.
    @(negedge clk);
    reset_chk();
    @(negedge clk);
    resetn = 1'b1;
    rr_m = 0;
    v = mk(2'b11, 2'b00, 32'h0000_0200, 32'h8000_0100, 32'h0, 32'h0, 8'h00, 0, 0,
           32'h4444_5555, 1'b0, 0, 32'h0000_0100);
    for (int i = 0; i < 4; i++) do_txn(v, i < 3);

    // Reset during WAIT, late data_ok, then round-robin pointer back at 0.
    do_txn(mk(2'b01, 2'b00, 32'h0, 32'h0000_0300, 32'h0, 32'h0, 8'h00, 0, 0,
              32'h0, 1'b0, 0, 32'h0000_0300), 1'b0);
    ch_req = 2'b01;
    @(negedge clk);
    ch_req = 2'b00;
    mem_addr_ok = 1'b1;
    #1;
    chk("abort_addr_ok", {ao1, ao0}, 4'b0101);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    #1;
    chk("abort_wait_busy", {busy1, busy0}, 2'b11);
    reset_chk();
    mem_data_ok = 1'b1;
    #1;
    chk("abort_late_data_ok_in_reset", {do1, do0}, 4'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("abort_late_data_ok_after", {do1, do0}, 4'b0);
    chk("abort_busy_after", {busy1, busy0}, 2'b00);
    rr_m = 0;
    do_txn(mk(2'b11, 2'b00, 32'h0000_0500, 32'h0000_0400, 32'h0, 32'h0, 8'h00, 0, 0,
              32'h6666_0000, 1'b0, 0, 32'h0000_0400), 1'b0);

    // Randomised transactions against the reference rules.
    for (int n = 0; n < 150; n++) begin
      v.req = 2'($urandom_range(0, 3));
      if (v.req == 2'b00) begin
        ch_req = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'($urandom_range(0, 1));
        @(negedge clk);
        #1;
        chk("rnd_idle_busy", {busy1, busy0}, 2'b00);
        chk("rnd_idle_data_ok", {do1, do0}, 4'b0);
        continue;
      end
      a0 = {3'($urandom_range(0, 7)), 29'($urandom)};
      a1 = {3'($urandom_range(0, 7)), 29'($urandom)};
      v.wr    = 2'($urandom_range(0, 3));
      v.addr  = {a1, a0};
      v.wdata = {32'($urandom), 32'($urandom)};
      v.wstrb = 8'($urandom);
      v.aw    = $urandom_range(0, 3);
      v.dw    = int'($urandom_range(0, 4)) - 1;
      v.rdata = $urandom;
      v.noise = 1'($urandom_range(0, 1));
      v.eg0   = pick_fixed(v.req);
      v.ea0   = xlate(v.addr[32*v.eg0 +: 32]);
      do_txn(v, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
